// File: rtl/onchip_mem_scanner_pkg.sv
// onchip_mem_scanner_pkg
// Shared types and constants for the on-chip memory scanner: FSM state
// encoding, memory geometry, and the byte-lane merge used to keep the
// shadow copy coherent with client writes.
package onchip_mem_scanner_pkg;

    localparam int NUM_WORDS = 4;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_GAP
    } state_t;

    // Lanes with be=1 take the new byte; the rest keep the old byte.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/onchip_mem_scanner_if.sv
// onchip_mem_scanner_if
// Avalon-MM bus between the scanner (master) and the single-port on-chip
// memory (slave).
//   avm_address     word address
//   avm_chipselect  access this cycle
//   avm_write       access is a write
//   avm_byteenable  byte lanes
//   avm_writedata   write data
//   avm_clken       memory clock enable
//   avm_readdata    memory output (1-cycle read latency)
interface onchip_mem_scanner_if;
    import onchip_mem_scanner_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [BE_W-1:0]   avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write, avm_byteenable,
               avm_writedata, avm_clken,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_byteenable,
               avm_writedata, avm_clken,
        output avm_readdata
    );

endinterface

// File: rtl/onchip_mem_scanner_mem_wr_buf.sv
// mem_wr_buf
// One-entry buffer for client write requests.
//   clk, reset_n                 clock, synchronous active-low reset
//   wr_valid/wr_ready            client handshake (ready = buffer empty)
//   wr_addr/wr_data/wr_be        client request fields
//   issue                        buffered write goes on the bus this cycle;
//                                the entry clears at the end of it
//   buf_addr/buf_data/buf_be     buffered request fields
module mem_wr_buf
    import onchip_mem_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              issue,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic [BE_W-1:0]   buf_be
);

    logic full_q;
    logic accept;

    // Gating with reset_n keeps a held entry off the bus during reset.
    assign wr_ready = ~full_q & reset_n;
    assign issue    = full_q & reset_n;
    assign accept   = wr_valid & wr_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
        end else if (accept) begin
            full_q <= 1'b1;
        end else if (issue) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
            buf_be   <= wr_be;
        end
    end

endmodule

// File: rtl/onchip_mem_scanner.sv
// onchip_mem_scanner
// Sole Avalon-MM master of a 4 x 32-bit on-chip memory. Continuously sweeps
// all words into shadow registers and forwards client writes through a
// one-entry buffer, merging them into the shadow copy.
//   clk, reset_n            clock, synchronous active-low reset
//   enable                  keep sweeping; 0 finishes the current sweep
//   avm (master modport)    memory bus
//   wr_valid/wr_ready       client write handshake
//   wr_addr/wr_data/wr_be   client write request
//   word0..word3            shadow copy of memory words 0..3
//   sweep_done              one-cycle pulse after a full sweep is captured
module onchip_mem_scanner
    import onchip_mem_scanner_pkg::*;
#(
    parameter int SCAN_GAP = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    onchip_mem_scanner_if.master avm,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [BE_W-1:0]      wr_be,
    output logic [DATA_W-1:0]    word0,
    output logic [DATA_W-1:0]    word1,
    output logic [DATA_W-1:0]    word2,
    output logic [DATA_W-1:0]    word3,
    output logic                 sweep_done
);

    localparam logic [31:0] GAP_LAST = (SCAN_GAP > 0) ? 32'(SCAN_GAP - 1) : 32'd0;

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] idx_q, idx_nxt;
    logic [31:0]       gap_cnt_q, gap_cnt_nxt;

    logic              wr_issue, rd_issue;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [BE_W-1:0]   buf_be;

    logic              rd_vld_p1;
    logic [ADDR_W-1:0] rd_addr_p1;
    logic              sweep_done_q;
    logic [DATA_W-1:0] shadow_q   [NUM_WORDS];
    logic [DATA_W-1:0] shadow_nxt [NUM_WORDS];

    mem_wr_buf u_wr_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .issue    (wr_issue),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .buf_be   (buf_be)
    );

    // A pending write owns the bus; the sweep index simply stalls.
    assign rd_issue = reset_n & (state_q == S_SCAN) & ~wr_issue;

    // Bus drive: stage p0 (access issued this cycle)
    assign avm.avm_clken = 1'b1;

    always_comb begin
        avm.avm_chipselect = wr_issue | rd_issue;
        avm.avm_write      = wr_issue;
        avm.avm_address    = '0;
        avm.avm_byteenable = '0;
        avm.avm_writedata  = '0;
        if (wr_issue) begin
            avm.avm_address    = buf_addr;
            avm.avm_byteenable = buf_be;
            avm.avm_writedata  = buf_data;
        end else if (rd_issue) begin
            avm.avm_address    = idx_q;
            avm.avm_byteenable = '1;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = idx_q;
        gap_cnt_nxt = gap_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_SCAN;
                    idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (rd_issue) begin
                    idx_nxt = idx_q + 1'b1;
                    if (idx_q == ADDR_W'(NUM_WORDS - 1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last read is always captured at the end of this cycle.
                gap_cnt_nxt = '0;
                if (SCAN_GAP == 0) state_nxt = enable ? S_SCAN : S_IDLE;
                else               state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_nxt = enable ? S_SCAN : S_IDLE;
                else                       gap_cnt_nxt = gap_cnt_q + 32'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            gap_cnt_q <= gap_cnt_nxt;
        end
    end

    // Capture: stage p1 (read data valid one cycle after issue)
    // Capture first, then merge the write, so written bytes win a collision.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) shadow_nxt[i] = shadow_q[i];
        if (rd_vld_p1) shadow_nxt[rd_addr_p1] = avm.avm_readdata;
        if (wr_issue)  shadow_nxt[buf_addr]   = be_merge(shadow_nxt[buf_addr], buf_data, buf_be);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_p1    <= 1'b0;
            sweep_done_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
        end else begin
            rd_vld_p1    <= rd_issue;
            sweep_done_q <= (state_q == S_DRAIN);
            shadow_q     <= shadow_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rd_addr_p1 <= idx_q;
    end

    assign word0      = shadow_q[0];
    assign word1      = shadow_q[1];
    assign word2      = shadow_q[2];
    assign word3      = shadow_q[3];
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_onchip_mem_scanner.sv
// Directed bench: two scanners (SCAN_GAP=3 and SCAN_GAP=0), each attached to
// a behavioural 1-cycle-latency memory model.
module tb_onchip_mem_scanner;
    import onchip_mem_scanner_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, wr_valid, mem_load;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ready, wr_ready_b, done, done_b;
    logic [31:0] w0, w1, w2, w3, z0, z1, z2, z3;

    int checks = 0;
    int errors = 0;

    onchip_mem_scanner_if bus_a ();
    onchip_mem_scanner_if bus_b ();

    onchip_mem_scanner #(.SCAN_GAP(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .avm(bus_a),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .word0(w0), .word1(w1), .word2(w2), .word3(w3), .sweep_done(done)
    );

    onchip_mem_scanner #(.SCAN_GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .avm(bus_b),
        .wr_valid(1'b0), .wr_ready(wr_ready_b), .wr_addr(2'd0),
        .wr_data(32'd0), .wr_be(4'd0),
        .word0(z0), .word1(z1), .word2(z2), .word3(z3), .sweep_done(done_b)
    );

    // Memory models
    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];
    int          wr_cnt_a;

    always @(posedge clk) begin
        if (mem_load) begin
            mem_a[0] <= 32'h11111111; mem_a[1] <= 32'h22222222;
            mem_a[2] <= 32'h33333333; mem_a[3] <= 32'h44444444;
            wr_cnt_a <= 0;
        end else if (bus_a.avm_chipselect) begin
            if (bus_a.avm_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus_a.avm_byteenable[b])
                        mem_a[bus_a.avm_address][8*b +: 8] <= bus_a.avm_writedata[8*b +: 8];
                wr_cnt_a <= wr_cnt_a + 1;
            end else begin
                bus_a.avm_readdata <= mem_a[bus_a.avm_address];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            mem_b[0] <= 32'h11111111; mem_b[1] <= 32'h22222222;
            mem_b[2] <= 32'h33333333; mem_b[3] <= 32'h44444444;
        end else if (bus_b.avm_chipselect && !bus_b.avm_write) begin
            bus_b.avm_readdata <= mem_b[bus_b.avm_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_chk(input string tag, input logic cs, input logic wr,
                           input logic [1:0] addr, input logic [3:0] be, input logic [31:0] wd);
        chk({tag, ".cs"},   {31'd0, bus_a.avm_chipselect}, {31'd0, cs});
        chk({tag, ".wr"},   {31'd0, bus_a.avm_write},      {31'd0, wr});
        chk({tag, ".addr"}, {30'd0, bus_a.avm_address},    {30'd0, addr});
        chk({tag, ".be"},   {28'd0, bus_a.avm_byteenable}, {28'd0, be});
        chk({tag, ".wd"},   bus_a.avm_writedata,           wd);
    endtask

    task automatic reset_vals(input string tag);
        bus_chk(tag, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
        chk({tag, ".clken"}, {31'd0, bus_a.avm_clken}, 32'd1);
        chk({tag, ".ready"}, {31'd0, wr_ready}, 32'd0);
        chk({tag, ".done"},  {31'd0, done}, 32'd0);
        chk({tag, ".w0"}, w0, 32'h0);
        chk({tag, ".w1"}, w1, 32'h0);
        chk({tag, ".w2"}, w2, 32'h0);
        chk({tag, ".w3"}, w3, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt0;
        reset_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; mem_load = 1'b1;
        wr_addr = 2'd0; wr_data = 32'd0; wr_be = 4'd0;
        repeat (3) tick();
        reset_vals("rst");
        mem_load = 1'b0;

        // Release reset with enable=1; first read one cycle later (S)
        reset_n = 1'b1; enable = 1'b1;
        tick();
        bus_chk("s1.r0", 1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
        chk("s1.ready", {31'd0, wr_ready}, 32'd1);
        chk("b.r0.cs", {31'd0, bus_b.avm_chipselect}, 32'd1);
        tick();
        bus_chk("s1.r1", 1'b1, 1'b0, 2'd1, 4'hF, 32'h0);
        tick();
        bus_chk("s1.r2", 1'b1, 1'b0, 2'd2, 4'hF, 32'h0);
        chk("s1.w0", w0, 32'h11111111);
        tick();
        bus_chk("s1.r3", 1'b1, 1'b0, 2'd3, 4'hF, 32'h0);
        chk("s1.w1", w1, 32'h22222222);
        tick();
        chk("s1.drain.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        chk("s1.drain.done", {31'd0, done}, 32'd0);
        chk("s1.w2", w2, 32'h33333333);
        chk("b.drain.cs", {31'd0, bus_b.avm_chipselect}, 32'd0);
        tick();
        chk("s1.done", {31'd0, done}, 32'd1);
        chk("s1.w3", w3, 32'h44444444);
        chk("s1.gap.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        chk("b.done", {31'd0, done_b}, 32'd1);
        chk("b.gap0.cs", {31'd0, bus_b.avm_chipselect}, 32'd1);
        chk("b.gap0.addr", {30'd0, bus_b.avm_address}, 32'd0);
        chk("b.w3", z3, 32'h44444444);
        tick();
        chk("s1.done.pulse", {31'd0, done}, 32'd0);
        chk("gap1.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        tick();
        chk("gap2.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        tick();
        bus_chk("s2.r0", 1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
        enable = 1'b0;
        repeat (8) tick();
        chk("idle.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        chk("b.idle.cs", {31'd0, bus_b.avm_chipselect}, 32'd0);
        chk("b.w0", z0, 32'h11111111);

        // Partial write while idle
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        chk("pw.ready0", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        bus_chk("pw.bus", 1'b1, 1'b1, 2'd2, 4'h5, 32'hAABBCCDD);
        chk("pw.ready1", {31'd0, wr_ready}, 32'd0);
        tick();
        chk("pw.w2", w2, 32'h33BB33DD);
        chk("pw.ready2", {31'd0, wr_ready}, 32'd1);
        chk("pw.after.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);

        // Read-back sweep, enable dropped right after it starts
        enable = 1'b1;
        tick();
        bus_chk("rb.r0", 1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
        enable = 1'b0;
        repeat (5) tick();
        chk("rb.done", {31'd0, done}, 32'd1);
        chk("rb.w2", w2, 32'h33BB33DD);
        repeat (3) tick();
        chk("rb.idle.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);

        // Write stealing the idx=1 slot
        enable = 1'b1;
        tick();
        bus_chk("ws.r0", 1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
        enable = 1'b0;
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 32'h5A5A5A5A; wr_be = 4'b1100;
        tick();
        wr_valid = 1'b0;
        bus_chk("ws.wr", 1'b1, 1'b1, 2'd1, 4'hC, 32'h5A5A5A5A);
        tick();
        bus_chk("ws.r1", 1'b1, 1'b0, 2'd1, 4'hF, 32'h0);
        chk("ws.w1.merge", w1, 32'h5A5A2222);
        tick();
        bus_chk("ws.r2", 1'b1, 1'b0, 2'd2, 4'hF, 32'h0);
        tick();
        bus_chk("ws.r3", 1'b1, 1'b0, 2'd3, 4'hF, 32'h0);
        tick();
        chk("ws.nodone", {31'd0, done}, 32'd0);
        tick();
        chk("ws.done", {31'd0, done}, 32'd1);
        chk("ws.w1", w1, 32'h5A5A2222);
        repeat (3) tick();

        // Collision: write to word 0 in word 0's capture cycle
        enable = 1'b1;
        tick();
        bus_chk("col.r0", 1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
        enable = 1'b0;
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 32'hCAFEF00D; wr_be = 4'b0011;
        tick();
        wr_valid = 1'b0;
        bus_chk("col.wr", 1'b1, 1'b1, 2'd0, 4'h3, 32'hCAFEF00D);
        tick();
        chk("col.w0", w0, 32'h1111F00D);
        repeat (4) tick();
        chk("col.done", {31'd0, done}, 32'd1);
        chk("col.w0.rb", w0, 32'h1111F00D);
        repeat (3) tick();

        // Back-pressure
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 32'h01020304; wr_be = 4'hF;
        chk("bp.ready0", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_data = 32'h0A0B0C0D;
        chk("bp.ready1", {31'd0, wr_ready}, 32'd0);
        bus_chk("bp.wr1", 1'b1, 1'b1, 2'd3, 4'hF, 32'h01020304);
        tick();
        chk("bp.ready2", {31'd0, wr_ready}, 32'd1);
        chk("bp.gap.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        chk("bp.w3a", w3, 32'h01020304);
        tick();
        wr_valid = 1'b0;
        bus_chk("bp.wr2", 1'b1, 1'b1, 2'd3, 4'hF, 32'h0A0B0C0D);
        tick();
        chk("bp.w3b", w3, 32'h0A0B0C0D);

        // Reset with the buffer full: the write must never reach the bus
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        tick();
        wr_valid = 1'b0;
        reset_n = 1'b0;
        cnt0 = wr_cnt_a;
        #1;
        chk("rr.cs.gated", {31'd0, bus_a.avm_chipselect}, 32'd0);
        tick();
        tick();
        reset_vals("rr");
        chk("rr.nowrite", wr_cnt_a, cnt0);
        chk("rr.mem2", mem_a[2], 32'h33BB33DD);
        reset_n = 1'b1;
        tick();
        chk("rr.ready", {31'd0, wr_ready}, 32'd1);
        chk("rr.idle.cs", {31'd0, bus_a.avm_chipselect}, 32'd0);
        tick();
        chk("rr.dropped", wr_cnt_a, cnt0);
        chk("rr.mem2b", mem_a[2], 32'h33BB33DD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
